// File: rtl/binary_race_pkg.sv
// Shared definitions for the binary racing game: state codes, LFSR constants, score width, colours.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package binary_race_pkg;

  localparam int SCORE_W = 4;

  // Game states, shared with the renderer
  localparam logic [2:0] ST_TITLE = 3'd0;
  localparam logic [2:0] ST_PLAY  = 3'd1;
  localparam logic [2:0] ST_SCORE = 3'd2;
  localparam logic [2:0] ST_WIN   = 3'd3;
  localparam logic [2:0] ST_LOSE  = 3'd4;

  // Galois LFSR for x^16+x^14+x^13+x^11+1, right-shifting
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // 12-bit RGB colours used by the renderer for sprites and background
  localparam logic [11:0] COLOR_BG     = 12'h000;
  localparam logic [11:0] COLOR_TARGET = 12'hFF0;
  localparam logic [11:0] COLOR_P0     = 12'hF00;
  localparam logic [11:0] COLOR_P1     = 12'h0F0;
  localparam logic [11:0] COLOR_P2     = 12'h00F;
  localparam logic [11:0] COLOR_P3     = 12'hF0F;
  localparam logic [11:0] COLOR_CPU    = 12'hFFF;

  // Score increment that sticks at the top of the range instead of wrapping
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == '1) ? s : s + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/binary_race_lfsr.sv
// Free-running 16-bit Galois LFSR; exposes its low WIDTH bits as the next target candidate.
// Latency: candidate changes every clk, registered output.
// Backpressure: none, advances unconditionally.
module binary_race_lfsr
  import binary_race_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] cand
);

  logic [15:0] lfsr;

  // Shift right each clk, folding the tap mask in when a one falls out of bit 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  assign cand = lfsr[WIDTH-1:0];

endmodule

// File: rtl/binary_race_core.sv
// Game FSM for the binary race: players match a random target, first to WIN_SCORE wins; CPU opponent under BINARY_RACE_CPU_EN.
// Latency: match sampled at edge k -> score/point/target/state at k+1 -> WIN or PLAY at k+2.
// Backpressure: none; inputs are sampled every clk, tick only paces the CPU opponent.
module binary_race_core
  import binary_race_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int WIDTH       = 8,
  parameter int WIN_SCORE   = 3,
  parameter int CPU_PERIOD  = 64,
  parameter int IDX_W       = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           tick,
  input  logic                           start_single,
  input  logic                           start_multi,
  input  logic [NUM_PLAYERS*WIDTH-1:0]   player_in,
  output logic [WIDTH-1:0]               target,
  output logic [2:0]                     state,
  output logic                           single_player,
  output logic [NUM_PLAYERS*SCORE_W-1:0] score,
  output logic [SCORE_W-1:0]             cpu_score,
  output logic [NUM_PLAYERS-1:0]         point,
  output logic [IDX_W-1:0]               winner
);

  logic [2:0]             state_q;
  logic [WIDTH-1:0]       target_q;
  logic                   single_q;
  logic [IDX_W-1:0]       winner_q;
  logic [NUM_PLAYERS-1:0] point_q;
  logic [NUM_PLAYERS-1:0] armed;
  logic [SCORE_W-1:0]     score_q [NUM_PLAYERS];
  logic [SCORE_W-1:0]     cpu_score_q;

  logic                   prev_single, prev_multi;
  logic                   edge_single, edge_multi, go_title;
  logic [NUM_PLAYERS-1:0] differ, match, hit_oh, win_flag;
  logic                   hit, win_any, cpu_lose;
  logic [IDX_W-1:0]       win_idx;
  logic [WIDTH-1:0]       cand, next_target;

  binary_race_lfsr #(.WIDTH(WIDTH)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .cand (cand)
  );

  // Button presses are rising edges between consecutive clk samples
  assign edge_single = start_single & ~prev_single;
  assign edge_multi  = start_multi & ~prev_multi;
  assign go_title    = ((state_q == ST_WIN) || (state_q == ST_LOSE)) && (edge_single || edge_multi);

  // Never present the same target twice in a row
  assign next_target = (cand == target_q) ? (cand ^ WIDTH'(1)) : cand;

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    assign differ[p]   = (player_in[p*WIDTH +: WIDTH] != target_q);
    // Only player 0 competes in single-player mode
    assign match[p]    = (state_q == ST_PLAY) && armed[p] && ((p == 0) || !single_q) && !differ[p];
    assign win_flag[p] = (score_q[p] >= SCORE_W'(WIN_SCORE));
    assign score[p*SCORE_W +: SCORE_W] = score_q[p];
  end

  // Lowest-index matching player is the only one that scores
  assign hit     = |match;
  assign hit_oh  = match & (~match + NUM_PLAYERS'(1));
  assign win_any = |win_flag;

  // Index of the lowest player that has reached the winning score
  always_comb begin
    win_idx = '0;
    for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
      if (win_flag[p]) win_idx = IDX_W'(p);
    end
  end

`ifdef BINARY_RACE_CPU_EN
  localparam int CNT_W = (CPU_PERIOD > 1) ? $clog2(CPU_PERIOD) : 1;
  logic [CNT_W-1:0] cpu_cnt;

  // CPU opponent: one point per CPU_PERIOD ticks; a wrap that collides with a player point waits for the next tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_cnt     <= '0;
      cpu_score_q <= '0;
    end else if ((state_q == ST_TITLE) || go_title) begin
      cpu_cnt     <= '0;
      cpu_score_q <= '0;
    end else if ((state_q == ST_PLAY) && single_q && tick) begin
      if (cpu_cnt == CNT_W'(CPU_PERIOD - 1)) begin
        if (!hit) begin
          cpu_cnt     <= '0;
          cpu_score_q <= sat_inc(cpu_score_q);
        end
      end else begin
        cpu_cnt <= cpu_cnt + CNT_W'(1);
      end
    end
  end

  assign cpu_lose = (state_q == ST_PLAY) && single_q && (cpu_score_q >= SCORE_W'(WIN_SCORE));
`else
  localparam int UNUSED_CPU_PERIOD = CPU_PERIOD;
  logic unused_tick;
  assign unused_tick = tick;
  assign cpu_score_q = '0;
  assign cpu_lose    = 1'b0;
`endif

  // Main game FSM with target load, re-arm tracking and score bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_TITLE;
      target_q    <= '0;
      single_q    <= 1'b0;
      winner_q    <= '0;
      point_q     <= '0;
      armed       <= '0;
      prev_single <= 1'b0;
      prev_multi  <= 1'b0;
      for (int p = 0; p < NUM_PLAYERS; p++) score_q[p] <= '0;
    end else begin
      prev_single <= start_single;
      prev_multi  <= start_multi;
      point_q     <= '0;
      case (state_q)
        ST_TITLE: begin
          armed <= '0;
          for (int p = 0; p < NUM_PLAYERS; p++) score_q[p] <= '0;
          if (edge_single || edge_multi) begin
            state_q  <= ST_PLAY;
            single_q <= edge_single;
            target_q <= next_target;
          end
        end
        ST_PLAY: begin
          armed <= armed | differ;
          if (cpu_lose) begin
            state_q  <= ST_LOSE;
            winner_q <= IDX_W'(NUM_PLAYERS);
          end else if (hit) begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
              if (hit_oh[p]) score_q[p] <= sat_inc(score_q[p]);
            end
            point_q  <= hit_oh;
            target_q <= next_target;
            armed    <= '0;
            state_q  <= ST_SCORE;
          end
        end
        ST_SCORE: begin
          armed <= armed | differ;
          if (win_any) begin
            state_q  <= ST_WIN;
            winner_q <= win_idx;
          end else begin
            state_q  <= ST_PLAY;
          end
        end
        ST_WIN, ST_LOSE: begin
          if (go_title) begin
            state_q <= ST_TITLE;
            armed   <= '0;
            for (int p = 0; p < NUM_PLAYERS; p++) score_q[p] <= '0;
          end
        end
        default: state_q <= ST_TITLE;
      endcase
    end
  end

  assign target        = target_q;
  assign state         = state_q;
  assign single_player = single_q;
  assign cpu_score     = cpu_score_q;
  assign point         = point_q;
  assign winner        = winner_q;

endmodule

// File: tb/tb_binary_race_core.sv
// Directed bench for binary_race_core with an expected-point scoreboard and a target-predicting LFSR model.
// Latency: n/a.
// Backpressure: n/a.
module tb_binary_race_core;
  import binary_race_pkg::*;

  localparam int NP = 2;
  localparam int W  = 8;
  localparam int WS = 3;
  localparam int CP = 4;
  localparam int IW = 3;

  logic              clk;
  logic              rst;
  logic              tick;
  logic              start_single;
  logic              start_multi;
  logic [NP*W-1:0]   player_in;
  logic [W-1:0]      target;
  logic [2:0]        state;
  logic              single_player;
  logic [NP*SCORE_W-1:0] score;
  logic [SCORE_W-1:0] cpu_score;
  logic [NP-1:0]     point;
  logic [IW-1:0]     winner;

  binary_race_core #(
    .NUM_PLAYERS (NP),
    .WIDTH       (W),
    .WIN_SCORE   (WS),
    .CPU_PERIOD  (CP),
    .IDX_W       (IW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .tick          (tick),
    .start_single  (start_single),
    .start_multi   (start_multi),
    .player_in     (player_in),
    .target        (target),
    .state         (state),
    .single_player (single_player),
    .score         (score),
    .cpu_score     (cpu_score),
    .point         (point),
    .winner        (winner)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] pt;
    logic [7:0] sc;
    logic [2:0] st;
    logic [7:0] tg;
  } exp_t;

  exp_t       sb[$];
  logic [15:0] m_lfsr;
  logic [7:0]  m_tgt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR: x^16+x^14+x^13+x^11+1 Galois, seed ACE1
  always @(posedge clk or negedge rst) begin
    if (!rst) m_lfsr <= 16'hACE1;
    else      m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] nxt(input logic [7:0] cand, input logic [7:0] cur);
    return (cand == cur) ? (cand ^ 8'h01) : cand;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called right after a match is driven: the load at the next edge uses the current LFSR value
  task automatic expect_point(input logic [1:0] pt, input logic [7:0] sc);
    exp_t e;
    m_tgt = nxt(m_lfsr[7:0], m_tgt);
    e.pt = pt;
    e.sc = sc;
    e.st = ST_SCORE;
    e.tg = m_tgt;
    sb.push_back(e);
  endtask

  task automatic wait_point();
    exp_t e;
    bit   seen;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      step();
      if (point !== 2'b00) seen = 1'b1;
    end
    chk("point_seen", {31'b0, seen}, 32'd1);
    chk("sb_size", sb.size(), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("point", {30'b0, point}, {30'b0, e.pt});
      chk("score", {24'b0, score}, {24'b0, e.sc});
      chk("state_score", {29'b0, state}, {29'b0, e.st});
      chk("new_target", {24'b0, target}, {24'b0, e.tg});
    end
  endtask

  task automatic score_one(input int p, input logic [1:0] pt, input logic [7:0] sc);
    player_in = {~m_tgt, ~m_tgt};
    step();
    player_in[p*W +: W] = m_tgt;
    expect_point(pt, sc);
    wait_point();
  endtask

  initial begin
    rst = 1'b0; tick = 1'b0; start_single = 1'b0; start_multi = 1'b0;
    player_in = '0; m_tgt = 8'h00;
    step(); step();
    chk("rst_state", state, ST_TITLE);
    chk("rst_target", target, 0);
    chk("rst_score", score, 0);
    chk("rst_cpu", cpu_score, 0);
    chk("rst_point", point, 0);
    chk("rst_winner", winner, 0);
    chk("rst_single", single_player, 0);
    chk("rst_lfsr", dut.u_lfsr.lfsr, 16'hACE1);
    rst = 1'b1;
    step(); step();

    // Multi-player start
    start_multi = 1'b1;
    m_tgt = nxt(m_lfsr[7:0], m_tgt);
    step();
    start_multi = 1'b0;
    chk("start_state", state, ST_PLAY);
    chk("start_single", single_player, 0);
    chk("start_target", target, m_tgt);
    checks++;
    assert (target !== 8'h00) else begin
      errors++;
      $error("FAIL target_nonzero: observed %0h expected nonzero", target);
    end
    step();

    // Player 1 scores while player 0 presets its switches to the upcoming target
    player_in[15:8] = m_tgt;
    expect_point(2'b10, 8'h10);
    player_in[7:0] = m_tgt;
    wait_point();
    step();
    chk("point_pulse_end", point, 0);
    chk("back_to_play", state, ST_PLAY);
    repeat (5) step();
    chk("preset_not_armed", score, 8'h10);

    // Toggle away and back re-arms player 0
    player_in[7:0] = m_tgt ^ 8'h80;
    step();
    player_in[7:0] = m_tgt;
    expect_point(2'b01, 8'h11);
    wait_point();

    // Simultaneous match: only player 0 scores
    player_in = {~m_tgt, ~m_tgt};
    step();
    player_in = {m_tgt, m_tgt};
    expect_point(2'b01, 8'h12);
    wait_point();

    // Third point for player 0 wins
    score_one(0, 2'b01, 8'h13);
    step();
    chk("win_state", state, ST_WIN);
    chk("win_winner", winner, 0);
    player_in = {m_tgt, ~m_tgt};
    repeat (4) step();
    chk("hold_state", state, ST_WIN);
    chk("hold_score", score, 8'h13);
    chk("hold_target", target, m_tgt);
    chk("hold_point", point, 0);
    start_multi = 1'b1;
    step();
    start_multi = 1'b0;
    chk("restart_state", state, ST_TITLE);
    chk("restart_score", score, 0);
    step();

    // Single-player game; player 1 matching must be ignored
    start_single = 1'b1;
    m_tgt = nxt(m_lfsr[7:0], m_tgt);
    step();
    start_single = 1'b0;
    chk("single_state", state, ST_PLAY);
    chk("single_flag", single_player, 1);
    chk("single_target", target, m_tgt);
    player_in = {~m_tgt, ~m_tgt};
    step();
    player_in[15:8] = m_tgt;
    for (int i = 1; i <= 12; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
`ifdef BINARY_RACE_CPU_EN
      if (i == 12) begin
        chk("cpu_final_score", cpu_score, 3);
        chk("cpu_final_play", state, ST_PLAY);
      end
`endif
      step();
`ifdef BINARY_RACE_CPU_EN
      if (i == 11) chk("cpu_before_last", cpu_score, 2);
`else
      if (i == 11) chk("cpu_disabled", cpu_score, 0);
`endif
    end
`ifdef BINARY_RACE_CPU_EN
    chk("lose_state", state, ST_LOSE);
    chk("lose_winner", winner, NP);
`else
    chk("practice_state", state, ST_PLAY);
`endif
    chk("single_p1_ignored", score, 0);

    // Fresh game, two points, then asynchronous reset mid-play
    rst = 1'b0;
    m_tgt = 8'h00;
    step();
    rst = 1'b1;
    step();
    start_multi = 1'b1;
    m_tgt = nxt(m_lfsr[7:0], m_tgt);
    step();
    start_multi = 1'b0;
    chk("regame_target", target, m_tgt);
    score_one(0, 2'b01, 8'h01);
    score_one(0, 2'b01, 8'h02);
    step();
    chk("pre_reset_state", state, ST_PLAY);
    chk("pre_reset_score", score, 8'h02);
    #2;
    rst = 1'b0;
    m_tgt = 8'h00;
    #1;
    chk("async_state", state, ST_TITLE);
    chk("async_score", score, 0);
    chk("async_target", target, 0);
    chk("async_lfsr", dut.u_lfsr.lfsr, 16'hACE1);
    step();
    rst = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/binary_race_core.md
# binary_race_core

Parametrised game-logic core for the binary racing game: N human players (plus an optional CPU opponent) race to match a pseudo-random WIDTH-bit target on their switch inputs, first to WIN_SCORE wins. Rendering-free. It exports state, target, per-player scores and a winner index to the VGA renderer, which derives sprite positions from scores. Successor to the fixed 8-bit, 2-player game FSM. Adds player count, target width, win score, input re-arm, an input-edge-qualified restart and a tick-paced CPU opponent.

## Interface
- NUM_PLAYERS, 2: human players, 1..4.
- WIDTH, 8: target/input width, 4..16.
- WIN_SCORE, 3: points to win, 1..15; SCORE_W = 4.
- CPU_PERIOD, 64: ticks per CPU point, ≥1.
- IDX_W, 3: winner index width.
- clk  in  1  system clock.
- rst  in  1  reset. Asynchronous, active-low.
- tick  in  1  game-rate enable, one clk wide. Paces the CPU only.
- start_single  in  1  title "1P" button (level; edge-detected internally).
- start_multi  in  1  title "2P" button (level; edge-detected internally).
- player_in  in  NUM_PLAYERS*WIDTH  player p at [p*WIDTH +: WIDTH].
- target  out  WIDTH  current target.
- state  out  3  TITLE=0, PLAY=1, SCORE=2, WIN=3, LOSE=4.
- single_player  out  1  mode latched at game start.
- score  out  NUM_PLAYERS*SCORE_W  player p at [p*SCORE_W +: SCORE_W].
- cpu_score  out  SCORE_W  CPU progress.
- point  out  NUM_PLAYERS  one-cycle pulse when player p scores.
- winner  out  IDX_W  player index; NUM_PLAYERS means CPU.

## Operation
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1. Free-runs every clk.
  - Candidate = lfsr[WIDTH-1:0].
  - If candidate equals current target, load candidate ^ 1. A new target never repeats the previous one.
- Start buttons: a press is a 0→1 edge between consecutive clk samples.
- TITLE: scores, cpu_score, tick counter cleared; armed all 0.
  - start_single edge → PLAY, single_player=1, load target.
  - start_multi edge → PLAY, single_player=0, load target.
  - Both edges in the same cycle → single wins.
- Armed bit per player: set when player_in[p] != target. Cleared on every target load.
  - A player whose switches already show a new target must change them before scoring.
- PLAY: match[p] = armed[p] && player_in[p]==target, for p < active count.
  - Active count = 1 if single_player, else NUM_PLAYERS.
  - Lowest-index match scores: score+1, point pulse, new target, → SCORE. Simultaneous matches: only lowest index scores.
  - single_player, CPU enabled: counter increments on tick; at CPU_PERIOD-1 it wraps and cpu_score+1.
  - A player match and a CPU point in the same cycle → player point takes priority; CPU increment deferred to the next tick.
- SCORE: one cycle.
  - Any score ≥ WIN_SCORE → WIN, winner = that index.
  - Else → PLAY.
- PLAY with cpu_score ≥ WIN_SCORE → LOSE, winner = NUM_PLAYERS.
- WIN / LOSE: hold all outputs. Any start edge → TITLE.
- Score saturates at 15. Counters never wrap past WIN_SCORE in a legal game.

## Timing
- Reset values: state TITLE, target 0, lfsr 16'hACE1, score/cpu_score 0, point 0, winner 0, single_player 0.
- Reset is asynchronous. Reset mid-game returns to TITLE the same instant.
- Timing chain for a player match (all outputs registered):
  - Match sampled at edge k.
  - At k+1: score, point, target and state=SCORE update.
  - At k+2: state = WIN or PLAY.
- Armed bit is registered. A target becomes scoreable no earlier than 2 clk after load, and only once the input differs from it.
- CPU timing: the WIN_SCORE·CPU_PERIOD-th tick in PLAY updates cpu_score. LOSE follows one clk later.

## Configuration
- BINARY_RACE_CPU_EN defined: CPU counter, cpu_score and LOSE path present.
- BINARY_RACE_CPU_EN undefined:
  - cpu_score tied 0; LOSE unreachable; tick ignored.
  - start_single still starts a 1-player practice game, ending only in WIN.

## Structure
- Package binary_race_pkg holds:
  - State encodings.
  - LFSR seed and tap mask.
  - SCORE_W.
  - The colour constants shared with the renderer.
- Sub-module binary_race_lfsr: free-running LFSR with candidate output.
  - Target load and anti-repeat stay in the core.

## Test plan
- Reset, then start_multi edge: state=1, target≠0. Player 1 sets target: score[1]=1, point[1] pulses one clk, state 2 then 1.
- Player 0 presets switches to a value, then a target equal to that value is forced (force lfsr): no point until player 0 toggles away and back. Then score[0]=1.
- Players 0 and 1 match the same cycle: only score[0] increments, point=2'b01.
- Player 0 scores 3 times: state 3, winner=0. Hold: no change. start_multi edge: state 0, scores 0.
- CPU_EN, CPU_PERIOD=4, start_single, no input, 12 ticks: cpu_score=3, state 4, winner=NUM_PLAYERS.
- rst low mid-PLAY with score[0]=2: immediately state 0, score 0, lfsr 16'hACE1.
